activate: RTL and testbench

ACTIVATE -- requirements
Module: activate

---
 rtl/activate.sv | 137 +++++++++++++
 tb/tb_activate.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/activate.sv
// Sigmoid activation stage with a backward (derivative) pass.
// Forward:  x (signed Q8.8) -> y (unsigned Q0.8) through a 4-segment
//           piecewise-linear sigmoid.
// Backward: e (signed Q8.8) -> d = (e * y*(1-y)) in signed Q8.8.
//
// state | meaning
// ARG   | waiting for x; arg_ready high
// ACT   | compute y from the captured x
// RES   | present y; hold until consumer takes it
// ERR   | waiting for e; err_ready high (training only)
// DER   | compute d from e and the y of the same sample
// FBK   | present d; hold until upstream takes it
module activate (
    input  logic        clock,
    input  logic        reset,
    input  logic        train,
    input  logic        arg_valid,
    input  logic [15:0] arg_data,
    output logic        arg_ready,
    output logic        res_valid,
    output logic [7:0]  res_data,
    input  logic        res_ready,
    input  logic        err_valid,
    input  logic [15:0] err_data,
    output logic        err_ready,
    output logic        fbk_valid,
    output logic [15:0] fbk_data,
    input  logic        fbk_ready
);

    // ARG is encoded as zero so a zero-initialised register starts idle.
    typedef enum logic [2:0] {
        ARG = 3'd0,
        ACT = 3'd1,
        RES = 3'd2,
        ERR = 3'd3,
        DER = 3'd4,
        FBK = 3'd5
    } state_t;

    state_t      state;
    logic [15:0] x_q;
    logic [15:0] e_q;
    logic [7:0]  y_q;
    logic [15:0] d_q;

    logic [16:0]        mag;
    logic [8:0]         p;
    logic [8:0]         y_full;
    logic [7:0]         y_next;
    logic [6:0]         g;
    logic signed [23:0] prod;
    logic [15:0]        d_next;

    assign arg_ready = (state == ARG);
    assign err_ready = (state == ERR);

    // Forward datapath: |x| (17 bits so 0x8000 maps to +32768), sigmoid, clamp.
    always_comb begin
        mag = x_q[15] ? (17'd0 - {1'b1, x_q}) : {1'b0, x_q};
        if (mag < 17'd256)
            p = 9'(mag >> 2) + 9'd128;
        else if (mag < 17'd608)
            p = 9'(mag >> 3) + 9'd160;
        else if (mag < 17'd1280)
            p = 9'(mag >> 5) + 9'd216;
        else
            p = 9'd256;
        y_full = x_q[15] ? (9'd256 - p) : p;
        y_next = y_full[8] ? 8'hFF : y_full[7:0];
    end

    // Backward datapath: g = y*(256-y)>>8 never exceeds 64, so e*g fits 24 bits.
    always_comb begin
        g      = 7'(({9'd0, y_q} * (17'd256 - {9'd0, y_q})) >> 8);
        prod   = $signed(e_q) * $signed({17'd0, g});
        d_next = 16'(prod >>> 8);
    end

    // Sequencer, operand capture and registered valid/data outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= ARG;
            x_q       <= 16'd0;
            e_q       <= 16'd0;
            y_q       <= 8'd0;
            d_q       <= 16'd0;
            res_valid <= 1'b0;
            res_data  <= 8'd0;
            fbk_valid <= 1'b0;
            fbk_data  <= 16'd0;
        end else begin
            case (state)
                ARG: begin
                    if (arg_valid) begin
                        x_q   <= arg_data;
                        state <= ACT;
                    end
                end
                ACT: begin
                    y_q   <= y_next;
                    state <= RES;
                end
                RES: begin
                    if (!res_valid) begin
                        res_valid <= 1'b1;
                        res_data  <= y_q;
                    end else if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= train ? ERR : ARG;
                    end
                end
                ERR: begin
                    if (err_valid) begin
                        e_q   <= err_data;
                        state <= DER;
                    end
                end
                DER: begin
                    d_q   <= d_next;
                    state <= FBK;
                end
                FBK: begin
                    if (!fbk_valid) begin
                        fbk_valid <= 1'b1;
                        fbk_data  <= d_q;
                    end else if (fbk_ready) begin
                        fbk_valid <= 1'b0;
                        state     <= ARG;
                    end
                end
                default: state <= ARG;
            endcase
        end
    end

endmodule

// File: tb/tb_activate.sv
// Directed bench for the activate stage: forward sweep, hold behaviour,
// backward pass, stray err_valid and reset in FBK.
module tb_activate;

    logic        clock = 1'b0;
    logic        reset;
    logic        train;
    logic        arg_valid;
    logic [15:0] arg_data;
    logic        arg_ready;
    logic        res_valid;
    logic [7:0]  res_data;
    logic        res_ready;
    logic        err_valid;
    logic [15:0] err_data;
    logic        err_ready;
    logic        fbk_valid;
    logic [15:0] fbk_data;
    logic        fbk_ready;

    int n_checks = 0;
    int n_errors = 0;

    activate dut (
        .clock     (clock),
        .reset     (reset),
        .train     (train),
        .arg_valid (arg_valid),
        .arg_data  (arg_data),
        .arg_ready (arg_ready),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_ready (res_ready),
        .err_valid (err_valid),
        .err_data  (err_data),
        .err_ready (err_ready),
        .fbk_valid (fbk_valid),
        .fbk_data  (fbk_data),
        .fbk_ready (fbk_ready)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present x at a negedge and complete the arg handshake.
    task automatic do_arg(input logic [15:0] x);
        arg_valid = 1'b1;
        arg_data  = x;
        for (int i = 0; i < 20 && !arg_ready; i++) @(negedge clock);
        check("arg_wait", arg_ready, 1'b1);
        @(posedge clock);
        @(negedge clock);
        arg_valid = 1'b0;
        arg_data  = 16'hA5A5;
    endtask

    // Called on the negedge after the arg handshake edge.
    task automatic do_res(input logic [7:0] exp_y, input int hold, input logic tr);
        check("res_early0", res_valid, 1'b0);
        @(posedge clock); @(negedge clock);
        check("res_early1", res_valid, 1'b0);
        @(posedge clock); @(negedge clock);
        check("res_valid", res_valid, 1'b1);
        check("res_data", res_data, exp_y);
        for (int i = 0; i < hold; i++) begin
            @(posedge clock); @(negedge clock);
            check("res_hold_valid", res_valid, 1'b1);
            check("res_hold_data", res_data, exp_y);
            check("res_hold_arg_ready", arg_ready, 1'b0);
        end
        train     = tr;
        res_ready = 1'b1;
        @(posedge clock); @(negedge clock);
        res_ready = 1'b0;
        train     = ~tr;
        err_valid = 1'b0;
        err_data  = 16'h0000;
        check("res_clear", res_valid, 1'b0);
        if (tr) check("err_ready", err_ready, 1'b1);
        else    check("back_to_arg", arg_ready, 1'b1);
    endtask

    // Called in ERR; if abort, pulse reset once fbk_valid is up.
    task automatic do_err(input logic [15:0] e, input logic [15:0] exp_d, input int hold, input logic abort);
        err_valid = 1'b1;
        err_data  = e;
        @(posedge clock); @(negedge clock);
        err_valid = 1'b0;
        err_data  = 16'h7777;
        check("fbk_early0", fbk_valid, 1'b0);
        @(posedge clock); @(negedge clock);
        check("fbk_early1", fbk_valid, 1'b0);
        @(posedge clock); @(negedge clock);
        check("fbk_valid", fbk_valid, 1'b1);
        check("fbk_data", fbk_data, exp_d);
        for (int i = 0; i < hold; i++) begin
            @(posedge clock); @(negedge clock);
            check("fbk_hold_valid", fbk_valid, 1'b1);
            check("fbk_hold_data", fbk_data, exp_d);
            check("fbk_hold_arg_ready", arg_ready, 1'b0);
        end
        if (abort) begin
            reset = 1'b1;
            @(posedge clock); @(negedge clock);
            reset = 1'b0;
            check("rst_fbk_valid", fbk_valid, 1'b0);
            check("rst_fbk_data", fbk_data, 16'h0000);
            check("rst_arg_ready", arg_ready, 1'b1);
        end else begin
            fbk_ready = 1'b1;
            @(posedge clock); @(negedge clock);
            fbk_ready = 1'b0;
            check("fbk_clear", fbk_valid, 1'b0);
            check("fbk_back_to_arg", arg_ready, 1'b1);
        end
    endtask

    typedef struct {
        logic [15:0] x;
        logic [7:0]  y;
    } vec_t;

    vec_t sweep[8] = '{
        '{16'h0100, 8'd192}, '{16'hFF00, 8'd64},  '{16'h025F, 8'd235},
        '{16'h0260, 8'd235}, '{16'h0500, 8'd255}, '{16'h8000, 8'd0},
        '{16'h7FFF, 8'd255}, '{16'h00FF, 8'd191}
    };

    initial begin
        reset     = 1'b1;
        train     = 1'b0;
        arg_valid = 1'b0;
        arg_data  = 16'h0000;
        res_ready = 1'b0;
        err_valid = 1'b0;
        err_data  = 16'h0000;
        fbk_ready = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        check("rst_arg_ready", arg_ready, 1'b1);
        check("rst_err_ready", err_ready, 1'b0);
        check("rst_res_valid", res_valid, 1'b0);
        check("rst_fbk_valid", fbk_valid, 1'b0);
        check("rst_res_data", res_data, 8'd0);
        check("rst_fbk_data", fbk_data, 16'd0);

        do_arg(16'h0000);
        do_res(8'd128, 0, 1'b0);

        foreach (sweep[i]) begin
            do_arg(sweep[i].x);
            do_res(sweep[i].y, 0, 1'b0);
        end

        do_arg(16'h0100);
        do_res(8'd192, 5, 1'b0);

        do_arg(16'h0000);
        do_res(8'd128, 0, 1'b1);
        do_err(16'h0100, 16'h0040, 0, 1'b0);

        do_arg(16'h0100);
        do_res(8'd192, 0, 1'b1);
        do_err(16'hFE00, 16'hFFA0, 5, 1'b0);

        err_valid = 1'b1;
        err_data  = 16'h4000;
        do_arg(16'h0000);
        do_res(8'd128, 0, 1'b1);
        do_err(16'h0100, 16'h0040, 0, 1'b0);

        do_arg(16'hFF00);
        do_res(8'd64, 0, 1'b1);
        do_err(16'h0100, 16'h0030, 0, 1'b1);

        do_arg(16'h0000);
        do_res(8'd128, 0, 1'b1);
        do_err(16'hFF00, 16'hFFC0, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
